// File: rtl/rambus_pkg.sv
// Shared definitions for the rambus burst reader: FSM encoding and the
// constants of the read-only Wishbone master.
package rambus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [3:0] SEL_ALL   = 4'hF;
  localparam int         ADDR_STEP = 4;

endpackage

// File: rtl/rambus_burst_reader_if.sv
// Wishbone classic bus bundle between the burst reader (master) and a
// rambus responder (slave).
interface rambus_burst_reader_if #(
  parameter int ADDR_WIDTH = 10
);

  logic                  cyc;
  logic                  stb;
  logic                  we;
  logic [3:0]            sel;
  logic [ADDR_WIDTH-1:0] adr;
  logic [31:0]           dat_w;
  logic [31:0]           dat_r;
  logic                  ack;

  modport master (
    output cyc, stb, we, sel, adr, dat_w,
    input  dat_r, ack
  );

  modport slave (
    input  cyc, stb, we, sel, adr, dat_w,
    output dat_r, ack
  );

endinterface

// File: rtl/rambus_sync_fifo.sv
// Single-clock FIFO; head word is always visible on pop_data, and storage
// is cleared on reset so an empty FIFO reads zero.
module rambus_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (PW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rambus_burst_reader.sv
// Burst reader: fetches word_count words over Wishbone classic into a FIFO
// and streams them out, throttling requests so the FIFO never overflows.
module rambus_burst_reader
  import rambus_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_n_i,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [7:0]            word_count,
  output logic                  busy,
  output logic                  done,
  output logic                  rambus_wb_clk_o,
  output logic                  rambus_wb_rst_o,
  output logic                  rambus_wb_cyc_o,
  output logic                  rambus_wb_stb_o,
  output logic                  rambus_wb_we_o,
  output logic [3:0]            rambus_wb_sel_o,
  output logic [31:0]           rambus_wb_dat_o,
  output logic [ADDR_WIDTH-1:0] rambus_wb_adr_o,
  input  logic                  rambus_wb_ack_i,
  input  logic [31:0]           rambus_wb_dat_i,
  output logic [31:0]           m_data,
  output logic                  m_valid,
  input  logic                  m_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr, addr_nxt;
  logic [7:0]            remaining, remaining_nxt;
  logic                  done_nxt;
  logic                  push, pop, full, empty;
  logic [CW-1:0]         count, count_post;

  assign rambus_wb_clk_o = wb_clk_i;
  assign rambus_wb_rst_o = ~wb_rst_n_i;
  assign rambus_wb_cyc_o = (state == FETCH);
  assign rambus_wb_stb_o = (state == FETCH);
  assign rambus_wb_we_o  = 1'b0;
  assign rambus_wb_sel_o = SEL_ALL;
  assign rambus_wb_dat_o = '0;
  assign rambus_wb_adr_o = addr;
  assign busy            = (state != IDLE);
  assign m_valid         = ~empty;

  // An ack outside FETCH has no cycle to belong to and is dropped here.
  assign push       = (state == FETCH) && rambus_wb_ack_i;
  assign pop        = m_valid && m_ready;
  assign count_post = count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};

  rambus_sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (wb_clk_i),
    .rst_n     (wb_rst_n_i),
    .push      (push),
    .push_data (rambus_wb_dat_i),
    .pop       (pop),
    .pop_data  (m_data),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      addr      <= addr_nxt;
      remaining <= remaining_nxt;
      done      <= done_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    addr_nxt      = addr;
    remaining_nxt = remaining;
    done_nxt      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          addr_nxt      = base_addr & ~ADDR_WIDTH'(3);
          remaining_nxt = word_count;
          if (word_count == 8'd0) done_nxt  = 1'b1;
          else                    state_nxt = FETCH;
        end
      end
      FETCH: begin
        if (rambus_wb_ack_i) begin
          addr_nxt      = addr + ADDR_WIDTH'(ADDR_STEP);
          remaining_nxt = remaining - 8'd1;
          if (remaining == 8'd1)                   state_nxt = DRAIN;
          else if (count_post == CW'(FIFO_DEPTH))  state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (!full) state_nxt = FETCH;
      end
      DRAIN: begin
        if (empty || (pop && count == CW'(1))) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rambus_burst_reader.sv
// Directed bench for rambus_burst_reader with a one-cycle-latency responder
// and queue scoreboards for bus addresses and streamed words.
module tb_rambus_burst_reader;

  localparam int AW = 10;

  logic          wb_clk_i = 1'b0;
  logic          wb_rst_n_i = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [7:0]    word_count = '0;
  logic          busy, done, wb_clk_fwd, wb_rst_fwd;
  logic [31:0]   m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;

  rambus_burst_reader_if #(.ADDR_WIDTH(AW)) bus ();

  rambus_burst_reader #(.FIFO_DEPTH(4), .ADDR_WIDTH(AW)) dut (
    .wb_clk_i        (wb_clk_i),
    .wb_rst_n_i      (wb_rst_n_i),
    .start           (start),
    .base_addr       (base_addr),
    .word_count      (word_count),
    .busy            (busy),
    .done            (done),
    .rambus_wb_clk_o (wb_clk_fwd),
    .rambus_wb_rst_o (wb_rst_fwd),
    .rambus_wb_cyc_o (bus.cyc),
    .rambus_wb_stb_o (bus.stb),
    .rambus_wb_we_o  (bus.we),
    .rambus_wb_sel_o (bus.sel),
    .rambus_wb_dat_o (bus.dat_w),
    .rambus_wb_adr_o (bus.adr),
    .rambus_wb_ack_i (bus.ack),
    .rambus_wb_dat_i (bus.dat_r),
    .m_data          (m_data),
    .m_valid         (m_valid),
    .m_ready         (m_ready)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int            tests_run = 0;
  int            tests_failed = 0;
  int            ack_count = 0;
  int            done_count = 0;
  bit            cyc_seen = 1'b0;
  logic [7:0]    test_id = 8'h00;
  logic [AW-1:0] exp_addr[$];
  logic [31:0]   exp_data[$];

  function automatic logic [31:0] dataFor(input logic [7:0] id, input logic [AW-1:0] a);
    return {id, 8'hA5, 6'b0, a};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Responder acknowledges one cycle after it sees a request.
  always @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      bus.ack   <= 1'b0;
      bus.dat_r <= '0;
    end else if (bus.cyc && bus.stb && !bus.ack) begin
      bus.ack   <= 1'b1;
      bus.dat_r <= dataFor(test_id, bus.adr);
    end else begin
      bus.ack   <= 1'b0;
    end
  end

  always @(negedge wb_clk_i) begin
    if (bus.cyc) cyc_seen = 1'b1;
    if (done) done_count++;
    if (bus.cyc && bus.stb && bus.ack) begin
      ack_count++;
      if (exp_addr.size() == 0) checkOutput("unexpected_ack", 32'd1, 32'd0);
      else checkOutput("bus_adr", 32'(bus.adr), 32'(exp_addr.pop_front()));
    end
    if (m_valid && m_ready) begin
      if (exp_data.size() == 0) checkOutput("unexpected_word", m_data, 32'hFFFF_FFFF);
      else checkOutput("stream_data", m_data, exp_data.pop_front());
    end
  end

  task automatic applyStimulus(input logic [AW-1:0] base, input logic [7:0] cnt);
    logic [AW-1:0] a;
    a = base & ~AW'(3);
    for (int i = 0; i < cnt; i++) begin
      exp_addr.push_back(a);
      exp_data.push_back(dataFor(test_id, a));
      a = a + AW'(4);
    end
    @(negedge wb_clk_i);
    base_addr  = base;
    word_count = cnt;
    start      = 1'b1;
    @(negedge wb_clk_i);
    start      = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int limit);
    int n;
    n = 0;
    while (!done && n < limit) begin
      @(negedge wb_clk_i);
      n++;
    end
    if (!done) checkOutput(tag, 32'd0, 32'd1);
  endtask

  task automatic runBasic();
    int d0;
    test_id = test_id + 8'd1;
    d0 = done_count;
    m_ready = 1'b1;
    applyStimulus(10'h010, 8'd3);
    checkOutput("basic_stb_latency", 32'(bus.stb), 32'd1);
    checkOutput("basic_busy", 32'(busy), 32'd1);
    waitDone("basic_done_timeout", 100);
    @(negedge wb_clk_i);
    @(negedge wb_clk_i);
    checkOutput("basic_done_pulses", 32'(done_count - d0), 32'd1);
    checkOutput("basic_busy_after", 32'(busy), 32'd0);
    checkOutput("basic_addr_left", 32'(exp_addr.size()), 32'd0);
    checkOutput("basic_data_left", 32'(exp_data.size()), 32'd0);
  endtask

  initial begin
    int a0, d0, n;

    repeat (3) @(negedge wb_clk_i);
    checkOutput("reset_rst_fwd", 32'(wb_rst_fwd), 32'd1);
    checkOutput("reset_cyc", 32'(bus.cyc), 32'd0);
    wb_rst_n_i = 1'b1;
    @(negedge wb_clk_i);
    checkOutput("idle_rst_fwd", 32'(wb_rst_fwd), 32'd0);
    checkOutput("idle_busy", 32'(busy), 32'd0);
    checkOutput("idle_done", 32'(done), 32'd0);
    checkOutput("idle_stb", 32'(bus.stb), 32'd0);
    checkOutput("idle_adr", 32'(bus.adr), 32'd0);
    checkOutput("idle_m_valid", 32'(m_valid), 32'd0);
    checkOutput("idle_m_data", m_data, 32'd0);
    checkOutput("tie_sel", 32'(bus.sel), 32'hF);
    checkOutput("tie_we", 32'(bus.we), 32'd0);
    checkOutput("tie_dat", bus.dat_w, 32'd0);

    runBasic();

    // Zero-length request finishes without touching the bus.
    cyc_seen = 1'b0;
    applyStimulus(10'h020, 8'd0);
    checkOutput("zero_done", 32'(done), 32'd1);
    checkOutput("zero_busy", 32'(busy), 32'd0);
    @(negedge wb_clk_i);
    checkOutput("zero_done_one_cycle", 32'(done), 32'd0);
    repeat (4) @(negedge wb_clk_i);
    checkOutput("zero_no_cyc", 32'(cyc_seen), 32'd0);

    // Back-pressure: four words fill the FIFO and the bus parks.
    test_id = 8'h40;
    m_ready = 1'b0;
    a0 = ack_count;
    applyStimulus(10'h040, 8'd6);
    repeat (20) @(negedge wb_clk_i);
    checkOutput("hold_ack_count", 32'(ack_count - a0), 32'd4);
    checkOutput("hold_cyc", 32'(bus.cyc), 32'd0);
    checkOutput("hold_stb", 32'(bus.stb), 32'd0);
    checkOutput("hold_busy", 32'(busy), 32'd1);
    checkOutput("hold_m_valid", 32'(m_valid), 32'd1);
    checkOutput("hold_head", m_data, dataFor(8'h40, 10'h040));
    m_ready = 1'b1;
    waitDone("hold_done_timeout", 200);
    @(negedge wb_clk_i);
    checkOutput("hold_total_acks", 32'(ack_count - a0), 32'd6);
    checkOutput("hold_data_left", 32'(exp_data.size()), 32'd0);

    // Address wrap at the top of the space.
    test_id = 8'h50;
    applyStimulus(10'h3F8, 8'd3);
    waitDone("wrap_done_timeout", 100);
    @(negedge wb_clk_i);
    checkOutput("wrap_addr_left", 32'(exp_addr.size()), 32'd0);
    checkOutput("wrap_adr_final", 32'(bus.adr), 32'h004);

    // Second start mid-burst must be ignored; low address bits are dropped.
    test_id = 8'h60;
    d0 = done_count;
    applyStimulus(10'h022, 8'd4);
    @(negedge wb_clk_i);
    base_addr  = 10'h200;
    word_count = 8'd9;
    start      = 1'b1;
    @(negedge wb_clk_i);
    start      = 1'b0;
    waitDone("restart_done_timeout", 100);
    repeat (6) @(negedge wb_clk_i);
    checkOutput("restart_done_pulses", 32'(done_count - d0), 32'd1);
    checkOutput("restart_busy", 32'(busy), 32'd0);
    checkOutput("restart_addr_left", 32'(exp_addr.size()), 32'd0);

    // Reset during FETCH with an ack pending abandons the burst.
    test_id = 8'h70;
    m_ready = 1'b0;
    a0 = ack_count;
    applyStimulus(10'h100, 8'd4);
    n = 0;
    while (!(bus.cyc && bus.ack && (ack_count - a0) >= 1) && n < 50) begin
      @(negedge wb_clk_i);
      n++;
    end
    checkOutput("rst_pending_ack", 32'(bus.ack && bus.cyc), 32'd1);
    d0 = done_count;
    wb_rst_n_i = 1'b0;
    #1;
    checkOutput("rst_cyc", 32'(bus.cyc), 32'd0);
    checkOutput("rst_stb", 32'(bus.stb), 32'd0);
    checkOutput("rst_m_valid", 32'(m_valid), 32'd1 - 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    exp_addr.delete();
    exp_data.delete();
    repeat (3) @(negedge wb_clk_i);
    wb_rst_n_i = 1'b1;
    repeat (3) @(negedge wb_clk_i);
    checkOutput("rst_no_done", 32'(done_count - d0), 32'd0);
    checkOutput("rst_m_data", m_data, 32'd0);
    checkOutput("rst_adr", 32'(bus.adr), 32'd0);

    runBasic();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    checkOutput("global_timeout", 32'd0, 32'd1);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/rambus_burst_reader.md
RAMBUS_BURST_READER -- requirements
Module: rambus_burst_reader

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4: read-data FIFO depth in 32-bit words, power of two, minimum 2.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10: rambus byte-address width.
REQ-003 SHALL have port wb_clk_i, input, 1 bit: the only clock; all logic rises on it.
REQ-004 SHALL have port wb_rst_n_i, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1 bit: one-cycle request to begin a burst.
REQ-006 SHALL have port base_addr, input, ADDR_WIDTH bits: first byte address; bits [1:0] are ignored.
REQ-007 SHALL have port word_count, input, 8 bits: number of words to read; 0 means none.
REQ-008 SHALL have port busy, output, 1 bit: high from accepted start until done.
REQ-009 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have ports rambus_wb_clk_o and rambus_wb_rst_o, outputs, 1 bit each: forwarded clock and active-high reset (~wb_rst_n_i).
REQ-011 SHALL have ports rambus_wb_cyc_o, rambus_wb_stb_o and rambus_wb_we_o, outputs, 1 bit each: Wishbone classic master controls; we is tied to 0.
REQ-012 SHALL have port rambus_wb_sel_o, output, 4 bits: tied to 4'hF.
REQ-013 SHALL have port rambus_wb_dat_o, output, 32 bits: tied to 0.
REQ-014 SHALL have port rambus_wb_adr_o, output, ADDR_WIDTH bits: word-aligned byte address.
REQ-015 SHALL have ports rambus_wb_ack_i, input, 1 bit, and rambus_wb_dat_i, input, 32 bits: responder acknowledge and read data.
REQ-016 SHALL have ports m_data, output, 32 bits; m_valid, output, 1 bit; m_ready, input, 1 bit: output stream carrying the FIFO head.

Function
REQ-017 SHALL implement FSM states IDLE, FETCH, HOLD and DRAIN.
REQ-018 In IDLE, start SHALL latch base_addr & ~3 and word_count, set busy the next cycle, and go to FETCH; with word_count=0 it SHALL instead pulse done the next cycle with no bus cycle and busy staying low.
REQ-019 In FETCH, cyc and stb SHALL both be high and adr SHALL be held stable until ack.
REQ-020 On ack, rambus_wb_dat_i SHALL be pushed into the FIFO, the address SHALL advance by 4 modulo 2^ADDR_WIDTH (wrap 0x3FC->0x000), and the remaining count SHALL decrement.
REQ-021 After an ack, with words remaining and post-cycle FIFO occupancy < FIFO_DEPTH, the FSM SHALL stay in FETCH, keep stb high and present the next address on the following cycle (back-to-back).
REQ-022 After an ack, with words remaining but the FIFO full after that cycle, the FSM SHALL go to HOLD with cyc and stb low, and return to FETCH in the cycle after occupancy drops below FIFO_DEPTH.
REQ-023 After the last ack, the FSM SHALL go to DRAIN with cyc and stb low.
REQ-024 In DRAIN, the block SHALL pulse done and return to IDLE (busy low) in the cycle after the final stream handshake empties the FIFO.
REQ-025 start while busy SHALL be ignored.
REQ-026 ack while cyc is low SHALL be ignored.
REQ-027 Request gating (REQ-021/022) SHALL guarantee no FIFO overflow.
REQ-028 A stream transfer SHALL occur when m_valid && m_ready.
REQ-029 A simultaneous push and pop SHALL leave occupancy unchanged.
REQ-030 m_valid SHALL be high iff the FIFO is non-empty; m_data SHALL equal the head entry and SHALL read 0 when the FIFO is empty after reset.
REQ-031 Stream order SHALL equal address order.
REQ-032 Minimum latency SHALL be: start at cycle N -> stb at N+1; ack at cycle K -> m_valid at K+1.

Reset
REQ-033 Asserting wb_rst_n_i low SHALL immediately force state IDLE; cyc, stb, busy, done and m_valid to 0; adr to 0; FIFO pointers and counters to 0.
REQ-034 Reset asserted mid-burst SHALL abandon the burst and flush the FIFO without emitting done.
REQ-035 Deassertion SHALL be used synchronously to wb_clk_i.

Structure
REQ-036 FSM state encoding and the tied constants (SEL_ALL=4'hF, address step 4) SHALL live in shared package rambus_pkg.
REQ-037 The FIFO SHALL be a sub-module named rambus_sync_fifo (parameters WIDTH and DEPTH; push, pop, full, empty and count outputs).

Verification
REQ-038 A bench SHALL cover: base_addr=0x010, word_count=3, ack one cycle after each stb, m_ready=1 -> adr 0x010, 0x014, 0x018; stream D0,D1,D2; one done pulse; busy low afterwards.
REQ-039 A bench SHALL cover: word_count=6, FIFO_DEPTH=4, m_ready=0 -> exactly 4 acks, cyc low in HOLD; raising m_ready resumes at the 5th address; all 6 words delivered in order.
REQ-040 A bench SHALL cover: base_addr=0x3F8, word_count=3 -> adr 0x3F8, 0x3FC, 0x000.
REQ-041 A bench SHALL cover: word_count=0 -> done one cycle after start; cyc never asserted.
REQ-042 A bench SHALL cover: start pulsed again during a burst -> ignored, with no change to adr or count.
REQ-043 A bench SHALL cover: wb_rst_n_i low during FETCH with a pending ack -> cyc, stb and m_valid drop at once; no done; a new start after release behaves per REQ-038.
